// File: rtl/instr_prefetch.sv
`default_nettype none
// ============================================================================
// Module   : instr_prefetch
// Purpose  : Instruction fetch unit with a DEPTH-entry sequential prefetch
//            buffer between the CPU fetch stage and an SDRAM read port.
//            Words at consecutive addresses are fetched ahead while the CPU
//            decodes; a fetch whose pc matches the buffer head completes in
//            one cycle, a non-matching pc flushes the buffer and redirects
//            the fetch stream.
// Ports    : clk, reset            - falling-edge clock, async active-high reset
//            pc, req, fin, instr   - CPU fetch handshake
//            sdram_rd_*            - single-outstanding SDRAM read port
//            flush                 - synchronous buffer invalidate
// Revision : 1.0 - initial release
// ============================================================================
module instr_prefetch #(
    parameter int XLEN   = 32,
    parameter int DEPTH  = 4,
    parameter int STRIDE = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc,
    input  logic            req,
    output logic            fin,
    output logic [XLEN-1:0] instr,
    output logic            sdram_rd_req,
    input  logic            sdram_rd_fin,
    input  logic [XLEN-1:0] sdram_rd_data,
    output logic [XLEN-1:0] sdram_rd_addr,
    input  logic            flush
);

    localparam int                c_ptr_w  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int                c_cnt_w  = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_full   = c_cnt_w'(DEPTH);
    localparam logic [XLEN-1:0]    c_stride = XLEN'(STRIDE);

    typedef enum logic [1:0] {
        M_IDLE    = 2'd0,
        M_BUSY    = 2'd1,
        M_DISCARD = 2'd2
    } mstate_t;

    typedef enum logic [1:0] {
        C_IDLE = 2'd0,
        C_WAIT = 2'd1,
        C_DONE = 2'd2
    } cstate_t;

    mstate_t              mstate_q, mstate_d;
    cstate_t              cstate_q, cstate_d;
    logic [XLEN-1:0]      fetch_addr_q, fetch_addr_d;
    logic                 stream_valid_q, stream_valid_d;
    logic [c_ptr_w-1:0]   rd_ptr_q, rd_ptr_d;
    logic [c_ptr_w-1:0]   wr_ptr_q, wr_ptr_d;
    logic [c_cnt_w-1:0]   count_q, count_d;
    logic                 fin_q, fin_d;
    logic [XLEN-1:0]      instr_q, instr_d;
    logic                 rd_req_q, rd_req_d;
    logic [XLEN-1:0]      rd_addr_q, rd_addr_d;
    logic [XLEN-1:0]      buf_addr_q [DEPTH];
    logic [XLEN-1:0]      buf_addr_d [DEPTH];
    logic [XLEN-1:0]      buf_data_q [DEPTH];
    logic [XLEN-1:0]      buf_data_d [DEPTH];

    logic                 w_head_valid;
    logic [XLEN-1:0]      w_head_addr;
    logic [XLEN-1:0]      w_head_data;
    logic [XLEN-1:0]      w_pend_addr;
    logic                 w_active;
    logic                 w_hit;
    logic                 w_miss;
    logic                 w_kill;
    logic                 w_push;
    logic                 w_issue;

    always_comb begin
        w_head_valid = (count_q != '0);
        w_head_addr  = buf_addr_q[rd_ptr_q];
        w_head_data  = buf_data_q[rd_ptr_q];
        // Next word the stream will deliver when the buffer is empty: the
        // in-flight read if one is live, otherwise the next issue address.
        w_pend_addr  = (mstate_q == M_BUSY) ? rd_addr_q : fetch_addr_q;
        w_active     = ((cstate_q == C_IDLE) && req) || (cstate_q == C_WAIT);
        w_hit        = w_active && !flush && w_head_valid && (w_head_addr == pc);
        w_miss       = w_active && !flush && !w_hit &&
                       (w_head_valid || !stream_valid_q || (w_pend_addr != pc));
        // A redirect or flush invalidates both buffer contents and any word
        // arriving in the same cycle.
        w_kill       = flush || w_miss;
        w_push       = (mstate_q == M_BUSY) && sdram_rd_fin && !w_kill &&
                       (count_q != c_full);
        // No issue on the redirect edge itself: the new stream address is
        // only in fetch_addr from the next cycle on.
        w_issue      = (mstate_q == M_IDLE) && stream_valid_q && !w_kill &&
                       (count_q != c_full);
    end

    // CPU side
    always_comb begin
        cstate_d = cstate_q;
        fin_d    = w_hit;
        instr_d  = w_hit ? w_head_data : instr_q;
        case (cstate_q)
            C_IDLE:  if (req) cstate_d = w_hit ? C_DONE : C_WAIT;
            C_WAIT:  if (w_hit) cstate_d = C_DONE;
            C_DONE:  cstate_d = C_IDLE;
            default: cstate_d = C_IDLE;
        endcase
    end

    // Prefetch buffer
    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        buf_addr_d = buf_addr_q;
        buf_data_d = buf_data_q;
        if (w_kill) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_push) begin
                buf_addr_d[wr_ptr_q] = rd_addr_q;
                buf_data_d[wr_ptr_q] = sdram_rd_data;
                wr_ptr_d             = c_ptr_w'(wr_ptr_q + 1'b1);
            end
            if (w_hit) begin
                rd_ptr_d = c_ptr_w'(rd_ptr_q + 1'b1);
            end
            count_d = count_q + c_cnt_w'(w_push) - c_cnt_w'(w_hit);
        end
    end

    // Fetch stream and memory side
    always_comb begin
        stream_valid_d = stream_valid_q;
        fetch_addr_d   = fetch_addr_q;
        mstate_d       = mstate_q;
        rd_req_d       = rd_req_q;
        rd_addr_d      = rd_addr_q;

        if (flush) begin
            stream_valid_d = 1'b0;
        end else if (w_miss) begin
            stream_valid_d = 1'b1;
            fetch_addr_d   = pc;
        end else if (w_issue) begin
            fetch_addr_d   = fetch_addr_q + c_stride;
        end

        case (mstate_q)
            M_IDLE: begin
                if (w_issue) begin
                    mstate_d  = M_BUSY;
                    rd_req_d  = 1'b1;
                    rd_addr_d = fetch_addr_q;
                end
            end
            M_BUSY: begin
                if (sdram_rd_fin) begin
                    mstate_d = M_IDLE;
                    rd_req_d = 1'b0;
                end else if (w_kill) begin
                    mstate_d = M_DISCARD;
                end
            end
            M_DISCARD: begin
                // The controller cannot abort a read; wait it out and drop it.
                if (sdram_rd_fin) begin
                    mstate_d = M_IDLE;
                    rd_req_d = 1'b0;
                end
            end
            default: begin
                mstate_d = M_IDLE;
                rd_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            mstate_q       <= M_IDLE;
            cstate_q       <= C_IDLE;
            fetch_addr_q   <= '0;
            stream_valid_q <= 1'b0;
            rd_ptr_q       <= '0;
            wr_ptr_q       <= '0;
            count_q        <= '0;
            fin_q          <= 1'b0;
            instr_q        <= '0;
            rd_req_q       <= 1'b0;
            rd_addr_q      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                buf_addr_q[i] <= '0;
                buf_data_q[i] <= '0;
            end
        end else begin
            mstate_q       <= mstate_d;
            cstate_q       <= cstate_d;
            fetch_addr_q   <= fetch_addr_d;
            stream_valid_q <= stream_valid_d;
            rd_ptr_q       <= rd_ptr_d;
            wr_ptr_q       <= wr_ptr_d;
            count_q        <= count_d;
            fin_q          <= fin_d;
            instr_q        <= instr_d;
            rd_req_q       <= rd_req_d;
            rd_addr_q      <= rd_addr_d;
            buf_addr_q     <= buf_addr_d;
            buf_data_q     <= buf_data_d;
        end
    end

    assign fin           = fin_q;
    assign instr         = instr_q;
    assign sdram_rd_req  = rd_req_q;
    assign sdram_rd_addr = rd_addr_q;

endmodule
`default_nettype wire
